// File: rtl/exec_step_pkg.sv
// exec_step_pkg: shared state encoding and default sizing for the execution step controller
package exec_step_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam int DEF_CNT_W      = 32;
    localparam int DEF_STEP_LIMIT = 1024;

endpackage

// File: rtl/toggle_event.sv
// toggle_event: turns a debounced toggle level into a one-cycle press event, armed after reset
module toggle_event (
    input  logic clock,
    input  logic reset,
    input  logic lvl,
    output logic ev
);

    logic armed;
    logic prev;

    // First clock after reset only captures the level; afterwards every flip becomes a registered event
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            armed <= 1'b0;
            prev  <= 1'b0;
            ev    <= 1'b0;
        end else begin
            armed <= 1'b1;
            prev  <= lvl;
            ev    <= armed & (lvl ^ prev);
        end
    end

endmodule

// File: rtl/exec_step_ctrl.sv
// exec_step_ctrl: run/step/halt control of the processor enable with a saturating executed-cycle count
// Optional EXEC_STEP_LIMIT_EN: each run auto-stops after STEP_LIMIT enabled cycles
module exec_step_ctrl
    import exec_step_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int STEP_LIMIT = DEF_STEP_LIMIT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run_lvl,
    input  logic             step_lvl,
    input  logic             halt,
    input  logic             clear,
    output logic             cpu_en,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt
);

    if (CNT_W < 1 || STEP_LIMIT < 1) begin : g_bad_param
        $error("exec_step_ctrl: CNT_W and STEP_LIMIT must be at least 1");
    end

    state_t state;
    state_t nxt;
    logic   run_ev;
    logic   step_ev;
    logic   budget_done;

    toggle_event u_run_ev (
        .clock (clock),
        .reset (reset),
        .lvl   (run_lvl),
        .ev    (run_ev)
    );

    toggle_event u_step_ev (
        .clock (clock),
        .reset (reset),
        .lvl   (step_lvl),
        .ev    (step_ev)
    );

`ifdef EXEC_STEP_LIMIT_EN
    localparam int BW = (STEP_LIMIT > 1) ? $clog2(STEP_LIMIT) : 1;

    logic [BW-1:0] run_budget;

    assign budget_done = (run_budget == '0);

    // Reload the budget on each RUN entry and spend one unit per enabled RUN cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            run_budget <= '0;
        else if (nxt == RUN && state != RUN)
            run_budget <= BW'(STEP_LIMIT - 1);
        else if (state == RUN && !budget_done)
            run_budget <= run_budget - 1'b1;
    end
`else
    assign budget_done = 1'b0;
`endif

    // Next-state rules: run beats step in IDLE, halt beats run_ev and budget expiry in RUN
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = run_ev ? RUN : (step_ev ? STEP : IDLE);
            RUN:     nxt = halt ? HALTED : ((run_ev || budget_done) ? IDLE : RUN);
            STEP:    nxt = halt ? HALTED : IDLE;
            HALTED:  nxt = clear ? IDLE : HALTED;
            default: nxt = IDLE;
        endcase
    end

    // State plus outputs decoded from the next state so they line up with the state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cpu_en    <= 1'b0;
            running   <= 1'b0;
            halted    <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            state   <= nxt;
            cpu_en  <= (nxt == RUN) || (nxt == STEP);
            running <= (nxt == RUN);
            halted  <= (nxt == HALTED);
            if (cpu_en && !(&cycle_cnt))
                cycle_cnt <= cycle_cnt + 1'b1;
        end
    end

endmodule
